// File: rtl/sevenseg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan bus (driver and receiver).
package sevenseg_pkg;

  localparam int DIGIT_W     = 4;
  localparam int SEL_W       = 5;
  localparam int SCAN_PERIOD = 80000;

  localparam logic [SEL_W-1:0] SEL_MO = 5'b00001;
  localparam logic [SEL_W-1:0] SEL_MT = 5'b00010;
  localparam logic [SEL_W-1:0] SEL_HO = 5'b00100;
  localparam logic [SEL_W-1:0] SEL_HT = 5'b01000;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    GOT_MO = 2'd1,
    GOT_MT = 2'd2,
    GOT_HO = 2'd3
  } frame_state_t;

  // Shift-and-add keeps the x10 out of a real multiplier.
  function automatic logic [6:0] times10(input logic [DIGIT_W-1:0] x);
    logic [6:0] w;
    w = {3'b000, x};
    return (w << 3) + (w << 1);
  endfunction

endpackage

// File: rtl/sevenseg_digit_filter.sv
// Synchronizes the scan bus and issues one accept pulse per {sel,data} pair
// once it has held steady for STABLE_CYCLES cycles.
module sevenseg_digit_filter
  import sevenseg_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DIGIT_W-1:0] data,
  output logic               acc_valid,
  output logic [SEL_W-1:0]   acc_sel,
  output logic [DIGIT_W-1:0] acc_data
);

  localparam int PAIR_W = SEL_W + DIGIT_W;
  localparam int CNT_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [PAIR_W-1:0] sync_q [SYNC_STAGES];
  logic [PAIR_W-1:0] cur;
  logic [PAIR_W-1:0] prev;
  logic [CNT_W-1:0]  count;
  logic              done;
  logic              changed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {sel, data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign cur       = sync_q[SYNC_STAGES-1];
  assign changed   = (cur != prev);
  assign acc_valid = !changed && !done && (count == LAST);
  assign acc_sel   = cur[PAIR_W-1:DIGIT_W];
  assign acc_data  = cur[DIGIT_W-1:0];

  // done starts set so whatever sits on the bus at reset is not taken as a digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= '0;
      count <= '0;
      done  <= 1'b1;
    end else begin
      prev <= cur;
      if (changed) begin
        count <= '0;
        done  <= 1'b0;
      end else if (acc_valid) begin
        done <= 1'b1;
      end else if (!done && count != LAST) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevenseg_scan_rx.sv
// Receive side of the 7-seg scan bus: reassembles mo/mt/ho/ht digits into a
// binary minute/hour frame and tracks link health with a timeout.
module sevenseg_scan_rx
  import sevenseg_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DIGIT_W-1:0] data,
  output logic [5:0]         minute,
  output logic [8:0]         houres,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               link_ok
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]         rst_pipe;
  logic               rst;
  logic               acc_valid;
  logic [SEL_W-1:0]   acc_sel;
  logic [DIGIT_W-1:0] acc_data;
  frame_state_t       state;
  logic [DIGIT_W-1:0] mo, mt, ho;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [SEL_W-1:0]   expected_sel;
  logic               sel_ok;
  logic [6:0]         minute_sum;
  logic [6:0]         hour_sum;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_pipe <= 2'b11;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst = rst_pipe[1];

  sevenseg_digit_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .data     (data),
    .acc_valid(acc_valid),
    .acc_sel  (acc_sel),
    .acc_data (acc_data)
  );

  always_comb begin
    expected_sel = SEL_MO;
    unique case (state)
      HUNT:   expected_sel = SEL_MO;
      GOT_MO: expected_sel = SEL_MT;
      GOT_MT: expected_sel = SEL_HO;
      GOT_HO: expected_sel = SEL_HT;
    endcase
  end

  assign sel_ok     = (acc_sel == SEL_MO) || (acc_sel == SEL_MT) ||
                      (acc_sel == SEL_HO) || (acc_sel == SEL_HT);
  assign minute_sum = times10(mt) + {3'b000, mo};
  assign hour_sum   = times10(acc_data) + {3'b000, ho};

  // An accept always wins over the timeout, since it also clears the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      mo          <= '0;
      mt          <= '0;
      ho          <= '0;
      minute      <= '0;
      houres      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      link_ok     <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (acc_valid) begin
        tmo_cnt <= '0;
        if (!sel_ok || acc_data > 4'd9) begin
          frame_err <= 1'b1;
          state     <= HUNT;
        end else if (acc_sel == expected_sel) begin
          unique case (state)
            HUNT: begin
              mo    <= acc_data;
              state <= GOT_MO;
            end
            GOT_MO: begin
              mt    <= acc_data;
              state <= GOT_MT;
            end
            GOT_MT: begin
              ho    <= acc_data;
              state <= GOT_HO;
            end
            GOT_HO: begin
              state <= HUNT;
              if (minute_sum > 7'd59) begin
                frame_err <= 1'b1;
              end else begin
                minute      <= minute_sum[5:0];
                houres      <= {2'b00, hour_sum};
                frame_valid <= 1'b1;
                link_ok     <= 1'b1;
              end
            end
          endcase
        end else if (state != HUNT) begin
          frame_err <= 1'b1;
          if (acc_sel == SEL_MO) begin
            mo    <= acc_data;
            state <= GOT_MO;
          end else begin
            state <= HUNT;
          end
        end
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (tmo_cnt == TMO_LAST) begin
          link_ok <= 1'b0;
          state   <= HUNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_rx.sv
// Directed bench for sevenseg_scan_rx with short filter/timeout parameters.
module tb_sevenseg_scan_rx;
  import sevenseg_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [4:0]   sel = 5'b00000;
  logic [3:0]   data = 4'd0;
  logic [5:0]   minute;
  logic [8:0]   houres;
  logic         frame_valid;
  logic         frame_err;
  logic         link_ok;

  int n_cmp = 0;
  int n_fail = 0;
  int fv_seen = 0;
  int fe_seen = 0;
  int both_seen = 0;

  sevenseg_scan_rx #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .data       (data),
    .minute     (minute),
    .houres     (houres),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .link_ok    (link_ok)
  );

  always #5 clk = ~clk;

  // Strobes are tallied on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (frame_valid) fv_seen++;
    if (frame_err) fe_seen++;
    if (frame_valid && frame_err) both_seen++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic hold_digit(input logic [4:0] s, input logic [3:0] d, input int n);
    sel  = s;
    data = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (minute !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_minute: got %0d expected 0", minute); end
    n_cmp++; if (houres !== 9'd0) begin n_fail++; $display("[TB] FAIL reset_houres: got %0d expected 0", houres); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_valid: got %b expected 0", frame_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_cmp++; if (link_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_link_ok: got %b expected 0", link_ok); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    int fv0, fe0, lat;
    fv0 = fv_seen; fe0 = fe_seen;
    hold_digit(SEL_MO, 4'd4, 10);
    hold_digit(SEL_MT, 4'd3, 10);
    hold_digit(SEL_HO, 4'd2, 10);
    sel = SEL_HT; data = 4'd1;
    lat = 0;
    while (!frame_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++; if (lat !== 7) begin n_fail++; $display("[TB] FAIL basic_latency: got %0d cycles expected 7", lat); end
    repeat (3) @(negedge clk);
    n_cmp++; if (fv_seen - fv0 !== 1) begin n_fail++; $display("[TB] FAIL basic_valid_count: got %0d expected 1", fv_seen - fv0); end
    n_cmp++; if (fe_seen - fe0 !== 0) begin n_fail++; $display("[TB] FAIL basic_err_count: got %0d expected 0", fe_seen - fe0); end
    n_cmp++; if (minute !== 6'd34) begin n_fail++; $display("[TB] FAIL basic_minute: got %0d expected 34", minute); end
    n_cmp++; if (houres !== 9'd12) begin n_fail++; $display("[TB] FAIL basic_houres: got %0d expected 12", houres); end
    n_cmp++; if (link_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_link_ok: got %b expected 1", link_ok); end
  endtask

  task automatic test_glitch;
    int fv0, fe0;
    fv0 = fv_seen; fe0 = fe_seen;
    hold_digit(SEL_MO, 4'd4, 10);
    hold_digit(SEL_MT, 4'd3, 2);
    hold_digit(SEL_MT, 4'd8, 2);
    hold_digit(SEL_MT, 4'd3, 7);
    hold_digit(SEL_HO, 4'd2, 10);
    hold_digit(SEL_HT, 4'd1, 10);
    n_cmp++; if (fe_seen - fe0 !== 0) begin n_fail++; $display("[TB] FAIL glitch_err_count: got %0d expected 0", fe_seen - fe0); end
    n_cmp++; if (fv_seen - fv0 !== 1) begin n_fail++; $display("[TB] FAIL glitch_valid_count: got %0d expected 1", fv_seen - fv0); end
    n_cmp++; if (minute !== 6'd34) begin n_fail++; $display("[TB] FAIL glitch_minute: got %0d expected 34", minute); end
  endtask

  task automatic test_order;
    int fv0, fe0;
    fv0 = fv_seen; fe0 = fe_seen;
    hold_digit(SEL_MO, 4'd9, 10);
    hold_digit(SEL_HO, 4'd5, 10);
    n_cmp++; if (fe_seen - fe0 !== 1) begin n_fail++; $display("[TB] FAIL order_err_count: got %0d expected 1", fe_seen - fe0); end
    hold_digit(SEL_MO, 4'd9, 10);
    hold_digit(SEL_MT, 4'd5, 10);
    hold_digit(SEL_HO, 4'd7, 10);
    hold_digit(SEL_HT, 4'd0, 10);
    n_cmp++; if (fv_seen - fv0 !== 1) begin n_fail++; $display("[TB] FAIL order_valid_count: got %0d expected 1", fv_seen - fv0); end
    n_cmp++; if (minute !== 6'd59) begin n_fail++; $display("[TB] FAIL order_minute: got %0d expected 59", minute); end
    n_cmp++; if (houres !== 9'd7) begin n_fail++; $display("[TB] FAIL order_houres: got %0d expected 7", houres); end
  endtask

  task automatic test_bcd_range;
    int fv0, fe0;
    fv0 = fv_seen; fe0 = fe_seen;
    hold_digit(SEL_MO, 4'd0, 10);
    hold_digit(SEL_MT, 4'hA, 10);
    hold_digit(SEL_HO, 4'd2, 10);
    hold_digit(SEL_HT, 4'd1, 10);
    n_cmp++; if (fe_seen - fe0 !== 1) begin n_fail++; $display("[TB] FAIL bcd_err_count: got %0d expected 1", fe_seen - fe0); end
    hold_digit(SEL_MO, 4'd0, 10);
    hold_digit(SEL_MT, 4'd6, 10);
    hold_digit(SEL_HO, 4'd2, 10);
    hold_digit(SEL_HT, 4'd1, 10);
    n_cmp++; if (fe_seen - fe0 !== 2) begin n_fail++; $display("[TB] FAIL range_err_count: got %0d expected 2", fe_seen - fe0); end
    n_cmp++; if (fv_seen - fv0 !== 0) begin n_fail++; $display("[TB] FAIL bcd_valid_count: got %0d expected 0", fv_seen - fv0); end
    n_cmp++; if (minute !== 6'd59 || houres !== 9'd7) begin
      n_fail++; $display("[TB] FAIL bcd_hold: got %0d:%0d expected 7:59", houres, minute);
    end
  endtask

  task automatic test_bad_select;
    int fv0, fe0;
    fv0 = fv_seen; fe0 = fe_seen;
    hold_digit(5'b00011, 4'd1, 10);
    hold_digit(5'b10000, 4'd1, 10);
    n_cmp++; if (fe_seen - fe0 !== 2) begin n_fail++; $display("[TB] FAIL badsel_err_count: got %0d expected 2", fe_seen - fe0); end
    fe0 = fe_seen;
    hold_digit(SEL_HO, 4'd3, 10);
    hold_digit(SEL_HT, 4'd2, 10);
    hold_digit(SEL_MO, 4'd5, 10);
    hold_digit(SEL_MT, 4'd4, 10);
    hold_digit(SEL_HO, 4'd3, 10);
    hold_digit(SEL_HT, 4'd2, 10);
    n_cmp++; if (fe_seen - fe0 !== 0) begin n_fail++; $display("[TB] FAIL midscan_err_count: got %0d expected 0", fe_seen - fe0); end
    n_cmp++; if (fv_seen - fv0 !== 1) begin n_fail++; $display("[TB] FAIL midscan_valid_count: got %0d expected 1", fv_seen - fv0); end
    n_cmp++; if (minute !== 6'd45) begin n_fail++; $display("[TB] FAIL midscan_minute: got %0d expected 45", minute); end
    n_cmp++; if (houres !== 9'd23) begin n_fail++; $display("[TB] FAIL midscan_houres: got %0d expected 23", houres); end
  endtask

  task automatic test_reset_mid_frame;
    int fv0, fe0;
    fv0 = fv_seen; fe0 = fe_seen;
    hold_digit(SEL_MO, 4'd7, 10);
    hold_digit(SEL_MT, 4'd1, 5);
    reset = 1'b1;
    #1;
    n_cmp++; if (minute !== 6'd0) begin n_fail++; $display("[TB] FAIL midreset_minute: got %0d expected 0", minute); end
    n_cmp++; if (houres !== 9'd0) begin n_fail++; $display("[TB] FAIL midreset_houres: got %0d expected 0", houres); end
    n_cmp++; if (link_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_link_ok: got %b expected 0", link_ok); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    hold_digit(SEL_MT, 4'd1, 5);
    hold_digit(SEL_HO, 4'd2, 10);
    hold_digit(SEL_HT, 4'd1, 10);
    n_cmp++; if (fv_seen - fv0 !== 0) begin n_fail++; $display("[TB] FAIL midreset_valid_count: got %0d expected 0", fv_seen - fv0); end
    n_cmp++; if (fe_seen - fe0 !== 0) begin n_fail++; $display("[TB] FAIL midreset_err_count: got %0d expected 0", fe_seen - fe0); end
  endtask

  task automatic test_timeout;
    int waited;
    hold_digit(SEL_MO, 4'd4, 10);
    hold_digit(SEL_MT, 4'd3, 10);
    hold_digit(SEL_HO, 4'd2, 10);
    sel = SEL_HT; data = 4'd1;
    waited = 0;
    while (!frame_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++; if (frame_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_frame_seen: got %b expected 1 within 20 cycles", frame_valid); end
    repeat (63) @(negedge clk);
    n_cmp++; if (link_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_link_before: got %b expected 1", link_ok); end
    @(negedge clk);
    n_cmp++; if (link_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_link_after: got %b expected 0", link_ok); end
    repeat (6) @(negedge clk);
    n_cmp++; if (link_ok !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_link_70: got %b expected 0", link_ok); end
    n_cmp++; if (minute !== 6'd34 || houres !== 9'd12) begin
      n_fail++; $display("[TB] FAIL timeout_hold: got %0d:%0d expected 12:34", houres, minute);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_glitch;
    test_order;
    test_bcd_range;
    test_bad_select;
    test_reset_mid_frame;
    test_timeout;
    n_cmp++; if (both_seen !== 0) begin n_fail++; $display("[TB] FAIL strobe_exclusive: got %0d overlaps expected 0", both_seen); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
